// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for the pipelined logic unit.
// slave = unit side, master = producer/consumer side.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [2:0]       out_op;
  logic             out_zero;
  logic             out_parity;

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y, out_op,
    output out_zero, out_parity
  );

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_op,
    input  out_zero, out_parity
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with opcode select,
// zero/parity flags and a STAGES-deep valid/ready pipeline.
module logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_unit_pipe_if.slave  i_bus
);

  logic [WIDTH-1:0] w_y;
  logic             w_zero;
  logic             w_par;
  logic [STAGES:0]  w_rdy;

  logic [STAGES-1:0]            r_vld;
  logic [STAGES-1:0][2:0]       r_op;
  logic [STAGES-1:0][WIDTH-1:0] r_y;
  logic [STAGES-1:0]            r_zero;
  logic [STAGES-1:0]            r_par;

  // Opcode decode and result flags, ahead of stage 0
  always_comb begin
    w_y = '0;
    unique case (i_bus.in_op)
      3'd0: w_y = i_bus.in_a & i_bus.in_b;
      3'd1: w_y = i_bus.in_a | i_bus.in_b;
      3'd2: w_y = ~i_bus.in_a;
      3'd3: w_y = ~(i_bus.in_a | i_bus.in_b);
      3'd4: w_y = i_bus.in_a ^ i_bus.in_b;
      3'd5: w_y = ~(i_bus.in_a & i_bus.in_b);
      3'd6: w_y = ~(i_bus.in_a ^ i_bus.in_b);
      3'd7: w_y = i_bus.in_a;
    endcase
    w_zero = (w_y == '0);
    w_par  = ^w_y;
  end

  // Ready ripples back from the consumer: a stage
  // accepts when empty or when it drains this edge
  always_comb begin
    w_rdy         = '0;
    w_rdy[STAGES] = i_bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_rdy[k] = !r_vld[k] || w_rdy[k+1];
    end
  end

  // Stage registers: stage 0 captures, later ones forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_op   <= '0;
      r_y    <= '0;
      r_zero <= '0;
      r_par  <= '0;
    end else begin
      if (w_rdy[0]) begin
        r_vld[0] <= i_bus.in_valid;
        if (i_bus.in_valid) begin
          r_op[0]   <= i_bus.in_op;
          r_y[0]    <= w_y;
          r_zero[0] <= w_zero;
          r_par[0]  <= w_par;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_op[k]   <= r_op[k-1];
            r_y[k]    <= r_y[k-1];
            r_zero[k] <= r_zero[k-1];
            r_par[k]  <= r_par[k-1];
          end
        end
      end
    end
  end

  assign i_bus.in_ready   = w_rdy[0];
  assign i_bus.out_valid  = r_vld[STAGES-1];
  assign i_bus.out_op     = r_op[STAGES-1];
  assign i_bus.out_y      = r_y[STAGES-1];
  assign i_bus.out_zero   = r_zero[STAGES-1];
  assign i_bus.out_parity = r_par[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: truth table, streaming,
// backpressure, full+simultaneous, reset and generics.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(8))  b8 ();
  logic_unit_pipe_if #(.WIDTH(1))  b1 ();
  logic_unit_pipe_if #(.WIDTH(32)) b32 ();

  logic_unit_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_bus(b8.slave)
  );
  logic_unit_pipe #(.WIDTH(1), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_bus(b1.slave)
  );
  logic_unit_pipe #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .i_bus(b32.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [7:0] a);
    b8.in_valid = 1'b1;
    b8.in_op    = 3'd7;
    b8.in_a     = a;
    b8.in_b     = 8'h00;
    #1;
    step();
    b8.in_valid = 1'b0;
  endtask

  logic [7:0]  exp8  [8] = '{8'h00, 8'hFF, 8'h3A, 8'h00,
                             8'hFF, 8'hFF, 8'h00, 8'hC5};
  logic        expz  [8] = '{1'b1, 1'b0, 1'b0, 1'b1,
                             1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] exp32 [8] = '{32'h0, 32'hFFFFFFFF,
                             32'h3A3A3A3A, 32'h0,
                             32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h0, 32'hC5C5C5C5};
  // Bit {a,b} of each row is the 1-bit gate output
  logic [3:0]  tbl1  [8] = '{4'b1000, 4'b1110, 4'b0011,
                             4'b0001, 4'b0110, 4'b0111,
                             4'b1001, 4'b1100};
  logic [7:0]  bpv   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    logic [7:0] q[$];
    logic [7:0] e;
    int idx;
    int seen;
    logic acc;
    logic [3:0] row;

    b8.in_valid = 0; b8.in_op = 0; b8.in_a = 0;
    b8.in_b = 0; b8.out_ready = 1;
    b1.in_valid = 0; b1.in_op = 0; b1.in_a = 0;
    b1.in_b = 0; b1.out_ready = 1;
    b32.in_valid = 0; b32.in_op = 0; b32.in_a = 0;
    b32.in_b = 0; b32.out_ready = 1;

    #12;
    chk("rst_vld", {31'b0, b8.out_valid}, 0);
    chk("rst_y", {24'b0, b8.out_y}, 0);
    chk("rst_op", {29'b0, b8.out_op}, 0);
    chk("rst_zp", {30'b0, b8.out_zero, b8.out_parity}, 0);
    #10 rst_n = 1'b1;
    step();
    chk("rst_rdy", {31'b0, b8.in_ready}, 1);

    // Truth table
    for (int op = 0; op < 8; op++) begin
      b8.in_valid = 1; b8.in_op = op[2:0];
      b8.in_a = 8'hC5; b8.in_b = 8'h3A;
      #1;
      step();
      b8.in_valid = 0;
      chk("t1_lat", {31'b0, b8.out_valid}, 0);
      step();
      chk("t1_vld", {31'b0, b8.out_valid}, 1);
      chk("t1_y", {24'b0, b8.out_y}, {24'b0, exp8[op]});
      chk("t1_z", {31'b0, b8.out_zero}, {31'b0, expz[op]});
      chk("t1_p", {31'b0, b8.out_parity}, 0);
      chk("t1_op", {29'b0, b8.out_op}, op);
    end
    step();

    // Streaming XOR
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        b8.in_valid = 1; b8.in_op = 3'd4;
        b8.in_a = i[7:0]; b8.in_b = 8'h0F;
        #1;
        chk("t2_rdy", {31'b0, b8.in_ready}, 1);
      end else begin
        b8.in_valid = 0;
      end
      step();
      if (i >= 1) begin
        e = (i[7:0] - 8'd1) ^ 8'h0F;
        chk("t2_vld", {31'b0, b8.out_valid}, 1);
        chk("t2_y", {24'b0, b8.out_y}, {24'b0, e});
        chk("t2_p", {31'b0, b8.out_parity}, {31'b0, ^e});
      end
    end
    step();
    chk("t2_empty", {31'b0, b8.out_valid}, 0);

    // Backpressure
    b8.out_ready = 0; b8.in_op = 3'd7; b8.in_b = 0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      b8.in_valid = 1; b8.in_a = bpv[idx];
      #1;
      acc = b8.in_ready;
      step();
      if (acc) idx++;
      if (c == 2) chk("t3_hold1", {24'b0, b8.out_y}, 32'h11);
    end
    chk("t3_acc", idx, 2);
    chk("t3_rdy", {31'b0, b8.in_ready}, 0);
    chk("t3_vld", {31'b0, b8.out_valid}, 1);
    chk("t3_hold2", {24'b0, b8.out_y}, 32'h11);
    b8.out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      b8.in_valid = (idx < 3);
      b8.in_a = bpv[idx];
      #1;
      if (b8.out_valid) q.push_back(b8.out_y);
      if (b8.in_valid && b8.in_ready) idx++;
      step();
    end
    b8.in_valid = 0;
    chk("t3_cnt", q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t3_ord", (q.size() > i) ? {24'b0, q[i]} : 32'hDEAD,
          {24'b0, bpv[i]});
    end

    // Full plus simultaneous in/out
    b8.out_ready = 0;
    push8(8'h44);
    push8(8'h55);
    b8.out_ready = 1; b8.in_valid = 1; b8.in_a = 8'h66;
    #1;
    chk("t4_rdy", {31'b0, b8.in_ready}, 1);
    chk("t4_y0", {24'b0, b8.out_y}, 32'h44);
    step();
    b8.in_valid = 0; b8.out_ready = 0;
    #1;
    chk("t4_full", {31'b0, b8.in_ready}, 0);
    chk("t4_y1", {24'b0, b8.out_y}, 32'h55);
    b8.out_ready = 1;
    step();
    chk("t4_vld2", {31'b0, b8.out_valid}, 1);
    chk("t4_y2", {24'b0, b8.out_y}, 32'h66);
    step();
    chk("t4_empty", {31'b0, b8.out_valid}, 0);

    // Reset mid-flight
    b8.out_ready = 0;
    push8(8'h77);
    push8(8'h88);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_vld", {31'b0, b8.out_valid}, 0);
    chk("t5_y", {24'b0, b8.out_y}, 0);
    #1 rst_n = 1'b1;
    b8.out_ready = 1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (b8.out_valid) seen++;
    end
    chk("t5_stale", seen, 0);
    chk("t5_rdy", {31'b0, b8.in_ready}, 1);

    // WIDTH=1, STAGES=1: 1-bit gate truth table
    for (int op = 0; op < 8; op++) begin
      row = tbl1[op];
      for (int ab = 0; ab < 4; ab++) begin
        b1.in_valid = 1; b1.in_op = op[2:0];
        b1.in_a = ab[1]; b1.in_b = ab[0];
        #1;
        step();
        chk("g1_vld", {31'b0, b1.out_valid}, 1);
        chk("g1_y", {31'b0, b1.out_y}, {31'b0, row[ab]});
      end
    end
    b1.in_valid = 0;
    step();
    chk("g1_empty", {31'b0, b1.out_valid}, 0);

    // WIDTH=32, STAGES=4
    for (int op = 0; op < 8; op++) begin
      b32.in_valid = 1; b32.in_op = op[2:0];
      b32.in_a = 32'hC5C5C5C5; b32.in_b = 32'h3A3A3A3A;
      #1;
      step();
      b32.in_valid = 0;
      step();
      step();
      chk("g32_lat", {31'b0, b32.out_valid}, 0);
      step();
      chk("g32_vld", {31'b0, b32.out_valid}, 1);
      chk("g32_y", b32.out_y, exp32[op]);
      chk("g32_z", {31'b0, b32.out_zero}, {31'b0, expz[op]});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
